// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input conditioning blocks.
// Defaults assume a 100 MHz clk_gen, a 1 ms sample tick and 10 ms acceptance.
package gpio_pkg;

   localparam int DEF_TICK_DIV     = 100_000;
   localparam int DEF_STABLE_TICKS = 10;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

   // Width that can hold values up to max_val, never narrower than 1.
   function automatic int cnt_width(input int max_val);
      int w;
      w = clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a tick-driven debounce filter
// with registered rise/fall pulses.
module debounce_bit
   import gpio_pkg::*;
#(
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic RESET_VAL    = 1'b0
) (
   input  logic clk_i,
   input  logic arst_n_i,
   input  logic tick_i,
   input  logic sw_i,
   output logic sw_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int               CNT_W    = cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         s1     <= RESET_VAL;
         s2     <= RESET_VAL;
         sw_o   <= RESET_VAL;
         cnt    <= '0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         s1     <= sw_i;
         s2     <= s1;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         // Any cycle back at the accepted level throws away partial progress.
         if (s2 == sw_o) begin
            cnt <= '0;
         end else if (tick_i) begin
            if (cnt == CNT_LAST) begin
               sw_o   <= s2;
               cnt    <= '0;
               rise_o <= s2;
               fall_o <= ~s2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounced slide-switch inputs for the mpss GPIO input bus: shared sample
// prescaler, per-bit filters and sticky write-1-to-clear change flags.
module gpio_in_debounce
   import gpio_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter int               TICK_DIV     = DEF_TICK_DIV,
   parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic [WIDTH-1:0] sw_i,
   output logic [WIDTH-1:0] sw_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic [WIDTH-1:0] chg_o,
   input  logic [WIDTH-1:0] clr_i
);

   localparam int                PCNT_W    = cnt_width(TICK_DIV - 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

   logic [PCNT_W-1:0] pcnt;
   logic              tick;

   // Free-running; with TICK_DIV=1 pcnt sits at 0 and tick is always high.
   assign tick = (pcnt == PCNT_LAST);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_VAL    (RESET_VAL[i])
      ) u_bit (
         .clk_i    (clk_i),
         .arst_n_i (arst_n_i),
         .tick_i   (tick),
         .sw_i     (sw_i[i]),
         .sw_o     (sw_o[i]),
         .rise_o   (rise_o[i]),
         .fall_o   (fall_o[i])
      );
   end

   // A new edge outranks a simultaneous clear so no change is ever lost.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         chg_o <= '0;
      end else begin
         chg_o <= (chg_o & ~clr_i) | rise_o | fall_o;
      end
   end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench: main instance at TICK_DIV=4/STABLE_TICKS=3, second instance
// at TICK_DIV=1/STABLE_TICKS=1.
module tb_gpio_in_debounce;

   logic        clk_i = 1'b0;
   logic        arst_n_i;
   logic [15:0] sw_i, clr_i, sw_o, rise_o, fall_o, chg_o;
   logic [15:0] m_sw_i, m_clr_i, m_sw_o, m_rise_o, m_fall_o, m_chg_o;
   int          total = 0;
   int          bad = 0;

   always #5 clk_i = ~clk_i;

   gpio_in_debounce #(
      .WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VAL(16'h0000)
   ) u_dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .sw_i(sw_i), .sw_o(sw_o),
      .rise_o(rise_o), .fall_o(fall_o), .chg_o(chg_o), .clr_i(clr_i)
   );

   gpio_in_debounce #(
      .WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VAL(16'h0000)
   ) u_min (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .sw_i(m_sw_i), .sw_o(m_sw_o),
      .rise_o(m_rise_o), .fall_o(m_fall_o), .chg_o(m_chg_o), .clr_i(m_clr_i)
   );

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle_and_clear();
      repeat (20) cyc();
      clr_i = 16'hFFFF;
      cyc();
      clr_i = 16'h0000;
   endtask

   task automatic test_reset();
      int n;
      arst_n_i = 1'b0;
      sw_i = 16'hFFFF; clr_i = 16'h0000;
      m_sw_i = 16'h0000; m_clr_i = 16'h0000;
      repeat (3) cyc();
      total++;
      if (sw_o !== 16'h0000) begin bad++; $display("FAIL reset_sw_o: got %h want 0000", sw_o); end
      total++;
      if ({rise_o, fall_o, chg_o} !== 48'h0) begin
         bad++; $display("FAIL reset_flags: rise=%h fall=%h chg=%h want 0", rise_o, fall_o, chg_o);
      end
      arst_n_i = 1'b1;
      n = 0;
      while (sw_o !== 16'hFFFF && n < 20) begin cyc(); n++; end
      total++;
      if (n < 11 || n > 14) begin bad++; $display("FAIL reset_latency: got %0d want 11..14", n); end
      total++;
      if (rise_o !== 16'hFFFF) begin bad++; $display("FAIL reset_rise: got %h want ffff", rise_o); end
      cyc();
      total++;
      if (rise_o !== 16'h0000) begin bad++; $display("FAIL reset_rise_width: got %h want 0000", rise_o); end
      total++;
      if (chg_o !== 16'hFFFF) begin bad++; $display("FAIL reset_chg: got %h want ffff", chg_o); end
   endtask

   task automatic test_chg_clear();
      clr_i = 16'h0008;
      cyc();
      clr_i = 16'h0000;
      total++;
      if (chg_o !== 16'hFFF7) begin bad++; $display("FAIL clr_bit3: got %h want fff7", chg_o); end
      sw_i = 16'h0000;
      settle_and_clear();
      total++;
      if (sw_o !== 16'h0000 || chg_o !== 16'h0000) begin
         bad++; $display("FAIL settle_low: sw=%h chg=%h want 0000/0000", sw_o, chg_o);
      end
   endtask

   task automatic test_min_params();
      int n;
      int highs, rises, falls;
      m_sw_i = 16'h0001;
      n = 0;
      while (m_sw_o[0] !== 1'b1 && n < 10) begin cyc(); n++; end
      total++;
      if (n != 3) begin bad++; $display("FAIL min_latency: got %0d want 3", n); end
      total++;
      if (m_rise_o !== 16'h0001) begin bad++; $display("FAIL min_rise: got %h want 0001", m_rise_o); end
      m_sw_i = 16'h0000;
      repeat (6) cyc();
      highs = 0; rises = 0; falls = 0;
      m_sw_i = 16'h0001;
      cyc();
      m_sw_i = 16'h0000;
      repeat (8) begin
         cyc();
         highs += int'(m_sw_o[0]);
         rises += int'(m_rise_o[0]);
         falls += int'(m_fall_o[0]);
      end
      total++;
      if (highs != 1 || rises != 1 || falls != 1) begin
         bad++; $display("FAIL min_pulse: high=%0d rise=%0d fall=%0d want 1/1/1", highs, rises, falls);
      end
   endtask

   task automatic test_clean_step();
      int n;
      sw_i = 16'h0008;
      n = 0;
      while (sw_o[3] !== 1'b1 && n < 20) begin cyc(); n++; end
      total++;
      if (n < 11 || n > 14) begin bad++; $display("FAIL step_latency: got %0d want 11..14", n); end
      total++;
      if (sw_o !== 16'h0008 || rise_o !== 16'h0008 || fall_o !== 16'h0000) begin
         bad++; $display("FAIL step_outputs: sw=%h rise=%h fall=%h want 0008/0008/0000", sw_o, rise_o, fall_o);
      end
      cyc();
      total++;
      if (rise_o !== 16'h0000 || chg_o !== 16'h0008) begin
         bad++; $display("FAIL step_after: rise=%h chg=%h want 0000/0008", rise_o, chg_o);
      end
      clr_i = 16'h0008;
      cyc();
      clr_i = 16'h0000;
      total++;
      if (chg_o !== 16'h0000) begin bad++; $display("FAIL clr_step: got %h want 0000", chg_o); end
   endtask

   task automatic test_set_wins();
      int n;
      sw_i = 16'h0000;
      settle_and_clear();
      sw_i = 16'h0008;
      n = 0;
      while (rise_o[3] !== 1'b1 && n < 20) begin cyc(); n++; end
      clr_i = 16'h0008;
      cyc();
      clr_i = 16'h0000;
      total++;
      if (chg_o !== 16'h0008 || sw_o !== 16'h0008) begin
         bad++; $display("FAIL set_wins: chg=%h sw=%h want 0008/0008", chg_o, sw_o);
      end
      clr_i = 16'h0008;
      cyc();
      clr_i = 16'h0000;
      total++;
      if (chg_o !== 16'h0000) begin bad++; $display("FAIL set_wins_clr: got %h want 0000", chg_o); end
   endtask

   task automatic test_glitch();
      int hits;
      hits = 0;
      sw_i[5] = 1'b1;
      repeat (3) begin
         cyc();
         hits += int'(sw_o[5] | rise_o[5] | fall_o[5] | chg_o[5]);
      end
      sw_i[5] = 1'b0;
      repeat (25) begin
         cyc();
         hits += int'(sw_o[5] | rise_o[5] | fall_o[5] | chg_o[5]);
      end
      total++;
      if (hits != 0) begin bad++; $display("FAIL glitch: active cycles got %0d want 0", hits); end
   endtask

   task automatic test_bounce();
      int rises, falls, both;
      rises = 0; falls = 0; both = 0;
      for (int seg = 0; seg < 6; seg++) begin
         sw_i[5] = (seg % 2 == 0);
         repeat (5) begin
            cyc();
            rises += int'(rise_o[5]);
            falls += int'(fall_o[5]);
            both  += int'(|(rise_o & fall_o));
         end
      end
      sw_i[5] = 1'b1;
      repeat (30) begin
         cyc();
         rises += int'(rise_o[5]);
         falls += int'(fall_o[5]);
         both  += int'(|(rise_o & fall_o));
      end
      total++;
      if (rises != 1 || falls != 0 || sw_o[5] !== 1'b1) begin
         bad++; $display("FAIL bounce: rise=%0d fall=%0d sw5=%b want 1/0/1", rises, falls, sw_o[5]);
      end
      total++;
      if (both != 0) begin bad++; $display("FAIL rise_and_fall: got %0d want 0", both); end
   endtask

   task automatic test_reset_mid();
      int n;
      int hits;
      sw_i = 16'h0000;
      settle_and_clear();
      sw_i = 16'h0080;
      repeat (10) cyc();
      total++;
      if (sw_o[7] !== 1'b0) begin bad++; $display("FAIL mid_early: sw7 got %b want 0", sw_o[7]); end
      #3 arst_n_i = 1'b0;
      #1;
      total++;
      if (sw_o !== 16'h0000 || {rise_o, fall_o, chg_o} !== 48'h0) begin
         bad++; $display("FAIL mid_async: sw=%h rise=%h fall=%h chg=%h want 0", sw_o, rise_o, fall_o, chg_o);
      end
      sw_i = 16'h0000;
      cyc(); cyc();
      arst_n_i = 1'b1;
      hits = 0;
      repeat (20) begin
         cyc();
         hits += int'(|{sw_o, rise_o, fall_o, chg_o});
      end
      total++;
      if (hits != 0) begin bad++; $display("FAIL mid_quiet: active cycles got %0d want 0", hits); end
      sw_i = 16'h0080;
      n = 0;
      while (sw_o[7] !== 1'b1 && n < 20) begin cyc(); n++; end
      total++;
      if (n < 11 || n > 14 || rise_o !== 16'h0080) begin
         bad++; $display("FAIL mid_restart: latency=%0d rise=%h want 11..14/0080", n, rise_o);
      end
   endtask

   initial begin
      test_reset();
      test_chg_clear();
      test_min_params();
      test_clean_step();
      test_set_wins();
      test_glitch();
      test_bounce();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Conditions raw board switch inputs before they reach the mpss GPIO input bus (gpio_bi).
- Per bit: a 2-flop synchronizer, then a debounce filter driven by a shared prescaler tick.
- Outputs a stable vector, single-cycle rise/fall pulses and sticky per-bit change flags with write-1-to-clear.
- Instanced in the board top between the slide-switch pins and mpss, clocked by clk_gen.

Parameters:
- WIDTH, 16, number of input bits.
- TICK_DIV, 100000, clk_i cycles per sample tick; must be >= 1.
- STABLE_TICKS, 10, consecutive mismatching ticks required to accept a new level; must be >= 1.
- RESET_VAL, {WIDTH{1'b0}}, reset value of the synchronizer flops and sw_o.

Ports:
- clk_i  input  1  system clock (clk_gen)
- arst_n_i  input  1  asynchronous active-low reset; board top drives it with CPU_RESETN & pll_locked
- sw_i  input  WIDTH  raw asynchronous pad inputs
- sw_o  output  WIDTH  debounced stable levels
- rise_o  output  WIDTH  1-cycle pulse: sw_o bit went 0->1
- fall_o  output  WIDTH  1-cycle pulse: sw_o bit went 1->0
- chg_o  output  WIDTH  sticky changed flag per bit
- clr_i  input  WIDTH  write-1-to-clear for chg_o, sampled every cycle

Behaviour:
- Reset (async assert, sync release by the board top):
  - s1, s2, sw_o = RESET_VAL.
  - rise_o, fall_o, chg_o, prescaler and all bit counters = 0.
  - Assertion mid-count drops all state immediately; no partial acceptance survives.
- Synchronizer: s1 <= sw_i; s2 <= s1. Only s2 is used downstream.
- Prescaler:
  - pcnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (pcnt == TICK_DIV-1), combinational.
  - TICK_DIV=1 gives tick constantly high.
- Per-bit filter, counter cnt is clog2(STABLE_TICKS+1) bits:
  - s2[i] == sw_o[i]: cnt <= 0 every cycle, regardless of tick.
  - mismatch && tick && cnt == STABLE_TICKS-1: sw_o[i] <= s2[i]; cnt <= 0; rise_o[i] or fall_o[i] <= 1.
  - mismatch && tick otherwise: cnt <= cnt+1.
  - mismatch && !tick: cnt holds.
  - A tick in the first cycle s2 mismatches counts.
  - Any return to match before acceptance discards progress.
- Pulses:
  - rise_o/fall_o are registered and high exactly the one cycle sw_o shows the new value, otherwise 0.
  - rise_o & fall_o is always 0.
- Latency from an s2 change to sw_o: (STABLE_TICKS-1)*TICK_DIV + k cycles, with k in 1..TICK_DIV. Add 2 cycles when measured from sw_i.
- chg_o:
  - Set on rise_o|fall_o, cleared by clr_i, both per bit.
  - Set and clear in the same cycle: set wins and chg_o stays 1.
  - Clear with no pending flag: no effect.
- Counters never exceed STABLE_TICKS-1. Prescaler wrap is free-running and unaffected by input activity.
- Bits are fully independent apart from the shared tick.

Decomposition:
- Shared package gpio_pkg holds:
  - a clog2 constant function;
  - default TICK_DIV/STABLE_TICKS constants for a 100 MHz clk_gen, 1 ms tick and 10 ms acceptance.
- One sub-module, debounce_bit: contains s1/s2, cnt, the sw_o bit and the pulse flops for a single bit; takes tick as input.
- Top holds the prescaler, chg_o logic and a generate loop of WIDTH debounce_bit instances.

Test Plan (TICK_DIV=4, STABLE_TICKS=3 unless stated):
- Reset: arst_n_i=0 with sw_i=16'hFFFF -> sw_o=0000, pulses and chg_o = 0. After release, sw_o=FFFF 11..14 cycles later, rise_o=FFFF for exactly 1 cycle, chg_o=FFFF.
- Clean step: sw_i[3] 0->1 and held -> sw_o[3]=1 11..14 cycles later, rise_o[3] one cycle, fall_o=0, other bits unchanged.
- Glitch/bounce:
  - sw_i[5] high for 3 cycles, then low -> sw_o[5], rise_o and chg_o[5] never change.
  - sw_i[5] toggling every 5 cycles for 30 cycles, then held 1 -> exactly one rise_o[5] pulse.
- chg clear:
  - clr_i[3]=1 one cycle with chg_o[3]=1 -> chg_o[3]=0 next cycle.
  - clr_i[3]=1 in the same cycle as rise_o[3] -> chg_o[3] stays 1.
- Reset mid-count: drop arst_n_i asynchronously while sw_i[7] mismatch is at count 2, then release with sw_i[7] at the RESET_VAL level -> sw_o[7]=0 immediately, no pulse ever, counter restarted.
- Minimal params (TICK_DIV=1, STABLE_TICKS=1): sw_i[0] 0->1 -> sw_o[0]=1 exactly 3 clk_i edges later, rise_o[0] coincident. A 1-cycle pulse on sw_i[0] yields a 1-cycle sw_o[0] pulse with both rise and fall reported.
